// File: rtl/reg_bank_burst.sv
// Host-visible configuration register bank with a level-strobe address/data
// handshake, optional auto-increment bursts, out-of-range error pulse,
// synchronous clear and the current address pointer exposed on addr_out.
module reg_bank_burst #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int WRAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic              write,
  input  logic              auto_inc,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] addr_out
);

  // Index width actually needed to select one of DEPTH registers.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [DATA_W:0]   DEPTH_CMP = (DATA_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_HOLD = 2'd1,
    RD_HOLD = 2'd2,
    ARMED   = 2'd3
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                burst_reg;
  logic [DATA_W-1:0]   data_out_reg;
  logic                valid_reg;
  logic                err_reg;
  logic [DATA_W-1:0]   regs [DEPTH];

  // Result of finishing a transfer: where the pointer and FSM go next.
  state_t              adv_state_next;
  logic [ADDR_W-1:0]   adv_addr_next;
  logic                adv_burst_next;
  logic                adv_err_next;
  logic                in_range;

  // The full data_in value is checked, so stray upper bits count as out of range.
  assign in_range = ({1'b0, data_in} < DEPTH_CMP);

  // Advance rule applied when a held strobe is released.
  always_comb begin
    adv_state_next = IDLE;
    adv_addr_next  = addr_reg;
    adv_burst_next = burst_reg;
    adv_err_next   = 1'b0;
    if (burst_reg) begin
      if (addr_reg != LAST_ADDR) begin
        adv_addr_next  = addr_reg + ADDR_W'(1);
        adv_state_next = ARMED;
      end else if (WRAP != 0) begin
        adv_addr_next  = '0;
        adv_state_next = ARMED;
      end else begin
        adv_err_next   = 1'b1;
        adv_burst_next = 1'b0;
        adv_state_next = IDLE;
      end
    end
  end

  // Handshake FSM, register storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      burst_reg    <= 1'b0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      err_reg <= 1'b0;
      if (clear) begin
        // data_out and the pointer are deliberately kept across a clear.
        for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        state_reg <= IDLE;
        valid_reg <= 1'b0;
        burst_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (read ^ write) begin
              if (in_range) begin
                addr_reg  <= data_in[ADDR_W-1:0];
                valid_reg <= 1'b1;
                burst_reg <= auto_inc;
                if (read) begin
                  data_out_reg <= regs[data_in[IDX_W-1:0]];
                  state_reg    <= RD_HOLD;
                end else begin
                  state_reg    <= WR_HOLD;
                end
              end else begin
                err_reg <= 1'b1;
              end
            end
          end
          WR_HOLD: begin
            // Data is taken on the cycle write drops; read is ignored here.
            if (!write) begin
              regs[addr_reg[IDX_W-1:0]] <= data_in;
              valid_reg <= 1'b0;
              state_reg <= adv_state_next;
              addr_reg  <= adv_addr_next;
              burst_reg <= adv_burst_next;
              err_reg   <= adv_err_next;
            end
          end
          RD_HOLD: begin
            if (!read) begin
              valid_reg <= 1'b0;
              state_reg <= adv_state_next;
              addr_reg  <= adv_addr_next;
              burst_reg <= adv_burst_next;
              err_reg   <= adv_err_next;
            end
          end
          ARMED: begin
            if (read && !write) begin
              data_out_reg <= regs[addr_reg[IDX_W-1:0]];
              valid_reg    <= 1'b1;
              state_reg    <= RD_HOLD;
            end else if (write && !read) begin
              valid_reg <= 1'b1;
              state_reg <= WR_HOLD;
            end else if (!read && !write && !auto_inc) begin
              burst_reg <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign data_out = data_out_reg;
  assign valid    = valid_reg;
  assign err      = err_reg;
  assign busy     = (state_reg != IDLE);
  assign addr_out = addr_reg;

endmodule

// File: tb/tb_reg_bank_burst.sv
// Bench for reg_bank_burst: a wrapping 256-deep instance and a non-wrapping
// 16-deep instance share one set of stimulus; read data is scoreboarded.
module tb_reg_bank_burst;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       read;
  logic       write;
  logic       auto_inc;
  logic       clear;

  logic [7:0] a_data_out, b_data_out;
  logic       a_valid, a_err, a_busy;
  logic       b_valid, b_err, b_busy;
  logic [7:0] a_addr_out, b_addr_out;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  reg_bank_burst #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .data_in(data_in), .read(read), .write(write),
    .auto_inc(auto_inc), .clear(clear), .data_out(a_data_out),
    .valid(a_valid), .err(a_err), .busy(a_busy), .addr_out(a_addr_out)
  );

  reg_bank_burst #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .WRAP(0)) u_nowrap (
    .clk(clk), .rst(rst), .data_in(data_in), .read(read), .write(write),
    .auto_inc(auto_inc), .clear(clear), .data_out(b_data_out),
    .valid(b_valid), .err(b_err), .busy(b_busy), .addr_out(b_addr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[9];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic sb_pop(input string name, input logic [7:0] act);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got 0x%0h want <empty scoreboard>", name, act);
    end else begin
      check(name, {24'd0, act}, {24'd0, exp_q.pop_front()});
    end
  endtask

  // Address phase held two cycles, data presented as write drops.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    data_in = addr;
    write   = 1'b1;
    cyc();
    check("wr_accept_valid", 32'(a_valid), 32'd1);
    cyc();
    write   = 1'b0;
    data_in = data;
    cyc();
    check("wr_done_valid", 32'(a_valid), 32'd0);
    data_in = 8'h00;
  endtask

  // Read with the expected value queued at issue and checked when valid rises.
  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp);
    int lat;
    bit got;
    exp_q.push_back(exp);
    data_in = addr;
    read    = 1'b1;
    got     = 1'b0;
    lat     = 0;
    while (!got && lat < 4) begin
      cyc();
      if (a_valid) got = 1'b1;
      else lat++;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL rd_timeout: got no valid want valid within 4 cycles (addr 0x%0h)", addr);
      void'(exp_q.pop_front());
    end else begin
      check("rd_latency", 32'(lat), 32'd0);
      sb_pop("rd_data", a_data_out);
    end
    read = 1'b0;
    cyc();
    check("rd_end_valid", 32'(a_valid), 32'd0);
    check("rd_end_busy", 32'(a_busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h10, 8'hA5};
    vecs[1] = '{1'b0, 8'h10, 8'hA5};
    vecs[2] = '{1'b1, 8'h00, 8'h3C};
    vecs[3] = '{1'b1, 8'h7F, 8'hC3};
    vecs[4] = '{1'b0, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 8'h7F, 8'hC3};
    vecs[6] = '{1'b0, 8'h05, 8'h00};
    vecs[7] = '{1'b1, 8'h10, 8'h5A};
    vecs[8] = '{1'b0, 8'h10, 8'h5A};

    data_in = 8'h00; read = 1'b0; write = 1'b0; auto_inc = 1'b0; clear = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_data_out", 32'(a_data_out), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_addr", 32'(a_addr_out), 32'd0);
    do_read(8'h05, 8'h00);

    // Table-driven single transfers.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               do_read(vecs[i].addr, vecs[i].data);
    end

    // Both strobes in IDLE: nothing happens.
    data_in = 8'h20; read = 1'b1; write = 1'b1;
    cyc();
    check("conflict_busy", 32'(a_busy), 32'd0);
    check("conflict_err", 32'(a_err), 32'd0);
    check("conflict_valid", 32'(a_valid), 32'd0);
    read = 1'b0; write = 1'b0;
    cyc();

    // Read pulse during WR_HOLD is ignored and the write still commits.
    data_in = 8'h21; write = 1'b1;
    cyc();
    read = 1'b1;
    cyc();
    check("wrhold_rdpulse_valid", 32'(a_valid), 32'd1);
    check("wrhold_rdpulse_busy", 32'(a_busy), 32'd1);
    check("wrhold_rdpulse_err", 32'(a_err), 32'd0);
    read = 1'b0; write = 1'b0; data_in = 8'h77;
    cyc();
    check("wrhold_commit_busy", 32'(a_busy), 32'd0);
    do_read(8'h21, 8'h77);

    // Burst write wrapping 0xFE -> 0xFF -> 0x00.
    auto_inc = 1'b1; data_in = 8'hFE; write = 1'b1;
    cyc();
    check("burst_addr_fe", 32'(a_addr_out), 32'hFE);
    write = 1'b0; data_in = 8'h11;
    cyc();
    check("burst_armed_busy", 32'(a_busy), 32'd1);
    check("burst_addr_ff", 32'(a_addr_out), 32'hFF);
    write = 1'b1; data_in = 8'h00;
    cyc();
    write = 1'b0; data_in = 8'h22;
    cyc();
    check("burst_addr_wrap", 32'(a_addr_out), 32'h00);
    write = 1'b1; data_in = 8'h00;
    cyc();
    write = 1'b0; data_in = 8'h33;
    cyc();
    check("burst_addr_end", 32'(a_addr_out), 32'h01);
    auto_inc = 1'b0; data_in = 8'h00;
    cyc();
    check("burst_exit_busy", 32'(a_busy), 32'd0);
    do_read(8'hFE, 8'h11);
    do_read(8'hFF, 8'h22);
    do_read(8'h00, 8'h33);

    // Overrun on the non-wrapping instance.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    data_in = 8'h0F; write = 1'b1;
    cyc();
    write = 1'b0; data_in = 8'h9C;
    cyc();
    exp_q.push_back(8'h9C);
    auto_inc = 1'b1; data_in = 8'h0F; read = 1'b1;
    cyc();
    check("ovr_valid", 32'(b_valid), 32'd1);
    sb_pop("ovr_rd_data", b_data_out);
    read = 1'b0;
    cyc();
    check("ovr_err_pulse", 32'(b_err), 32'd1);
    check("ovr_idle", 32'(b_busy), 32'd0);
    check("ovr_valid_low", 32'(b_valid), 32'd0);
    auto_inc = 1'b0;
    cyc();
    check("ovr_err_single", 32'(b_err), 32'd0);
    data_in = 8'h10; read = 1'b1;
    cyc();
    check("oor_err", 32'(b_err), 32'd1);
    check("oor_valid", 32'(b_valid), 32'd0);
    read = 1'b0;
    cyc();
    check("oor_err_single", 32'(b_err), 32'd0);

    // Clear during WR_HOLD: no commit, all registers zeroed, pointer held.
    do_write(8'h03, 8'h66);
    data_in = 8'h03; write = 1'b1;
    cyc();
    clear = 1'b1; write = 1'b0; data_in = 8'h55;
    cyc();
    clear = 1'b0;
    check("clear_busy", 32'(a_busy), 32'd0);
    check("clear_valid", 32'(a_valid), 32'd0);
    check("clear_addr_held", 32'(a_addr_out), 32'h03);
    do_read(8'h03, 8'h00);
    do_read(8'h0F, 8'h00);

    // Reset during RD_HOLD.
    do_write(8'h08, 8'h44);
    data_in = 8'h08; read = 1'b1;
    cyc();
    check("rdhold_data", 32'(a_data_out), 32'h44);
    rst = 1'b1;
    cyc();
    check("rst_rdhold_data", 32'(a_data_out), 32'd0);
    check("rst_rdhold_valid", 32'(a_valid), 32'd0);
    check("rst_rdhold_busy", 32'(a_busy), 32'd0);
    rst = 1'b0; read = 1'b0;
    cyc();
    do_read(8'h08, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
